// File: rtl/piso_pkg.sv
// Shared definitions for the piso_stream parallel-in/serial-out shifter.
//   state_t   : FSM encoding (IDLE, SHIFT)
//   ORDER_*   : meaning of the msb_first / ord flag
//   clog2     : bit-counter width helper
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic ORDER_MSB = 1'b1;
  localparam logic ORDER_LSB = 1'b0;

  // Bits needed to hold values 0..v-1 (v >= 2).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// WIDTH-bit shift register with clear, load, shift and hold.
//   clk   : rising-edge clock
//   clr   : synchronous clear to zero (highest priority)
//   load  : capture d
//   shift : shift one place toward the output end, zero-filled
//   dir   : ORDER_MSB shifts left (output is q[WIDTH-1]), else right (q[0])
//   d     : parallel load data
//   q     : register contents
module piso_shift_core
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      if (dir == ORDER_MSB) q <= {q[WIDTH-2:0], 1'b0};
      else                  q <= {1'b0, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with valid/ready on both sides.
//   clk, rst_n          : clock, synchronous active-low reset
//   pi, pi_valid        : parallel word from the producer
//   pi_ready            : word accepted this cycle when pi_valid is also high
//   msb_first           : bit order, captured with the word
//   so, so_valid        : serial bit toward the consumer
//   so_ready            : consumer takes so this cycle
//   so_last             : so is the final bit of the word
//   busy                : a word is in flight
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pi,
  input  logic             pi_valid,
  output logic             pi_ready,
  input  logic             msb_first,
  output logic             so,
  output logic             so_valid,
  input  logic             so_ready,
  output logic             so_last,
  output logic             busy
);

  localparam int CNT_W = clog2(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ord;
  logic [WIDTH-1:0] sr;

  logic accept;
  logic xfer;
  logic at_end;

  assign so_valid = (state == SHIFT);
  assign at_end   = (cnt == '0);
  assign so_last  = so_valid && at_end;
  assign busy     = so_valid;
  assign so       = (ord == ORDER_MSB) ? sr[WIDTH-1] : sr[0];

  // Ready also during the final bit's transfer so the next word reloads
  // without an idle cycle; never ready while reset is asserted.
  assign pi_ready = rst_n && ((state == IDLE) || (so_last && so_ready));
  assign accept   = pi_valid && pi_ready;
  assign xfer     = so_valid && so_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ord   <= ORDER_LSB;
    end else if (accept) begin
      state <= SHIFT;
      cnt   <= CNT_W'(WIDTH - 1);
      ord   <= msb_first;
    end else if (xfer) begin
      if (!at_end) cnt   <= cnt - 1'b1;
      else         state <= IDLE;
    end
  end

  // The register is cleared after the final bit so so reads 0 when idle.
  piso_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .clr   (!rst_n || (xfer && at_end && !accept)),
    .load  (accept),
    .shift (xfer && !at_end),
    .dir   (ord),
    .d     (pi),
    .q     (sr)
  );

endmodule

// File: tb/tb_piso_stream.sv
module tb_piso_stream;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] pi = '0;
  logic         pi_valid = 1'b0;
  logic         pi_ready;
  logic         msb_first = 1'b0;
  logic         so;
  logic         so_valid;
  logic         so_ready = 1'b1;
  logic         so_last;
  logic         busy;

  piso_stream #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .pi(pi), .pi_valid(pi_valid), .pi_ready(pi_ready),
    .msb_first(msb_first), .so(so), .so_valid(so_valid), .so_ready(so_ready),
    .so_last(so_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } ent_t;

  ent_t q[$];          // expected bits still to be transferred
  logic got[$];        // bits the DUT actually transferred
  int   xt[$];         // cycle index of each transfer
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   vcnt = 0;
  int   nlast = 0;
  bit   chk_en = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is just a list of bits in transmit order.
  always @(posedge clk) begin
    logic rdy;
    if (!rst_n) begin
      q.delete();
      chk_en = 1;
    end else begin
      rdy = (q.size() == 0) || (q.size() == 1 && so_ready);
      if (q.size() > 0 && so_ready) void'(q.pop_front());
      if (pi_valid && rdy) begin
        for (int i = 0; i < W; i++) begin
          ent_t e;
          e.b    = msb_first ? pi[W-1-i] : pi[i];
          e.last = (i == W - 1);
          q.push_back(e);
        end
      end
    end
  end

  // Monitor: compare DUT outputs to the head of the expected queue.
  always @(negedge clk) begin
    if (chk_en) begin
      logic ev, es, el, er;
      cyc++;
      ev = (q.size() > 0);
      es = ev ? q[0].b : 1'b0;
      el = ev ? q[0].last : 1'b0;
      er = rst_n && ((q.size() == 0) || (q.size() == 1 && so_ready));
      chk("so_valid", 16'(so_valid), 16'(ev));
      chk("so", 16'(so), 16'(es));
      chk("so_last", 16'(so_last), 16'(el));
      chk("busy", 16'(busy), 16'(ev));
      chk("pi_ready", 16'(pi_ready), 16'(er));
      if (so_valid) vcnt++;
      if (so_valid && so_ready) begin
        got.push_back(so);
        xt.push_back(cyc);
        if (so_last) nlast++;
      end
    end
  end

  function automatic logic [15:0] packed_got();
    logic [15:0] v;
    v = '0;
    foreach (got[i]) v = {v[14:0], got[i]};
    return v;
  endfunction

  task automatic send(input logic [W-1:0] w, input logic o);
    bit ok;
    ok = 0;
    pi = w; msb_first = o; pi_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (pi_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 16'd1, 16'd0);
    @(posedge clk); #1;
    pi_valid = 1'b0; pi = W'($urandom); msb_first = 1'($urandom);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!so_valid) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 16'd1, 16'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    // Reset, with pi_valid asserted to show it is not accepted.
    rst_n = 1'b0; pi_valid = 1'b1; pi = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_so_valid", 16'(so_valid), 16'd0);
    chk("rst_pi_ready", 16'(pi_ready), 16'd0);
    #1 rst_n = 1'b1; pi_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_pi_ready", 16'(pi_ready), 16'd1);
    @(posedge clk); #1;

    // Basic MSB-first.
    got.delete();
    send(4'b1101, 1'b1);
    drain();
    chk("basic_bits", packed_got(), 16'b1101);
    chk("basic_len", 16'(got.size()), 16'd4);
    @(negedge clk);
    chk("basic_idle_busy", 16'(busy), 16'd0);
    chk("basic_idle_ready", 16'(pi_ready), 16'd1);
    @(posedge clk); #1;

    // LSB-first; send() scrambles msb_first right after accept.
    got.delete();
    send(4'b1011, 1'b0);
    msb_first = 1'b1;
    drain();
    chk("lsb_bits", packed_got(), 16'b1101);

    // Back-to-back words must occupy 8 contiguous cycles.
    got.delete(); xt.delete();
    send(4'b1100, 1'b1);
    send(4'b1101, 1'b1);
    drain();
    chk("b2b_bits", packed_got(), 16'b11001101);
    chk("b2b_len", 16'(got.size()), 16'd8);
    if (xt.size() == 8) chk("b2b_contig", 16'(xt[7] - xt[0]), 16'd7);
    else chk("b2b_xfers", 16'(xt.size()), 16'd8);

    // Backpressure while the second bit is presented.
    got.delete(); vcnt = 0;
    send(4'b1101, 1'b1);
    @(posedge clk); #1 so_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_so", 16'(so), 16'd1);
      chk("stall_valid", 16'(so_valid), 16'd1);
      @(posedge clk); #1;
    end
    so_ready = 1'b1;
    drain();
    chk("bp_bits", packed_got(), 16'b1101);
    chk("bp_cycles", 16'(vcnt), 16'd7);

    // Reset mid-word: no so_last for the aborted word.
    n0 = nlast;
    send(4'b1011, 1'b1);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 16'(pi_ready), 16'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_valid", 16'(so_valid), 16'd0);
    chk("mid_rst_so", 16'(so), 16'd0);
    chk("mid_rst_ready2", 16'(pi_ready), 16'd0);
    chk("mid_rst_nolast", 16'(nlast), 16'(n0));
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    got.delete();
    send(4'b0110, 1'b1);
    drain();
    chk("after_rst_bits", packed_got(), 16'b0110);
    chk("after_rst_len", 16'(got.size()), 16'd4);

    // Idle hygiene.
    for (int i = 0; i < 20; i++) begin
      pi = W'($urandom); msb_first = 1'($urandom); so_ready = 1'($urandom);
      @(negedge clk);
      chk("idle_valid", 16'(so_valid), 16'd0);
      chk("idle_so", 16'(so), 16'd0);
      chk("idle_busy", 16'(busy), 16'd0);
      @(posedge clk); #1;
    end

    // Randomised traffic; the monitor checks every cycle against the model.
    for (int i = 0; i < 600; i++) begin
      pi_valid  = ($urandom_range(0, 3) != 0);
      pi        = W'($urandom);
      msb_first = 1'($urandom);
      so_ready  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    pi_valid = 1'b0; so_ready = 1'b1;
    drain();

    // Continuous traffic with so_ready=1 keeps so_valid high.
    vcnt = 0;
    pi_valid = 1'b1; pi = 4'b1001; msb_first = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      pi = W'($urandom); msb_first = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("full_rate", 16'(vcnt), 16'd40);
    pi_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
